// File: rtl/cm_pkg.sv
// cm_pkg: shared common helpers
package cm_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/cm_fifo2vr_adapter.sv
// cm_fifo2vr_adapter: non-show-ahead FIFO to valid/ready burst stream via 2-entry skid buffer
module cm_fifo2vr_adapter
  import cm_pkg::*;
#(
  parameter int WIDTH_DATA = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  fifo_rd_en,
  input  logic [WIDTH_DATA-1:0] fifo_rd_dout,
  input  logic                  fifo_empty,
  output logic [WIDTH_DATA-1:0] dns_data,
  output logic                  dns_valid,
  input  logic                  dns_ready,
  output logic                  dns_last,
  output logic [1:0]            buf_cnt
);
  localparam int CW = clog2(BURST_LEN) < 1 ? 1 : clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  logic [WIDTH_DATA-1:0] mem [2];
  logic [1:0] occ;
  logic [2:0] slots;
  logic [CW-1:0] beat;
  logic head, inflight, pop;
  assign dns_valid = occ != 2'd0;
  assign dns_data = mem[head];
  assign dns_last = dns_valid & (beat == LAST);
  assign buf_cnt = occ;
  assign pop = dns_valid & dns_ready;
  assign slots = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fifo_rd_en = !fifo_empty & !clr & !rst & (slots < 3'd2);
  always_ff @(posedge clk) begin
    if (rst | clr) begin
      occ <= '0;
      head <= 1'b0;
      inflight <= 1'b0;
      beat <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) mem[head ^ occ[0]] <= fifo_rd_dout;
      if (pop) begin
        head <= ~head;
        beat <= beat == LAST ? '0 : beat + CW'(1);
      end
      occ <= slots[1:0];
    end
  end
endmodule

// File: tb/tb_cm_fifo2vr_adapter.sv
// tb_cm_fifo2vr_adapter: random/directed bench with queue-based FIFO and stream scoreboard
module tb_cm_fifo2vr_adapter;
  logic clk, rst, clr;
  logic rd_en [2];
  logic [31:0] dout [2];
  logic empty [2];
  logic [31:0] data [2];
  logic valid [2], ready [2], last [2];
  logic [1:0] cnt [2];
  logic hold [2];
  logic [31:0] fq [2][$];
  logic [31:0] exq [2][$];
  int bl [2] = '{8, 1};
  int eb [2], hs [2];
  logic stall [2], pl [2], last_rd [2];
  logic [31:0] pd [2];
  int checks = 0, errors = 0;
  int h, pend;

  cm_fifo2vr_adapter #(.WIDTH_DATA(32), .BURST_LEN(8)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .fifo_rd_en(rd_en[0]), .fifo_rd_dout(dout[0]),
    .fifo_empty(empty[0]), .dns_data(data[0]), .dns_valid(valid[0]), .dns_ready(ready[0]),
    .dns_last(last[0]), .buf_cnt(cnt[0]));
  cm_fifo2vr_adapter #(.WIDTH_DATA(32), .BURST_LEN(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .fifo_rd_en(rd_en[1]), .fifo_rd_dout(dout[1]),
    .fifo_empty(empty[1]), .dns_data(data[1]), .dns_valid(valid[1]), .dns_ready(ready[1]),
    .dns_last(last[1]), .buf_cnt(cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO: data appears one cycle after the strobe; everything read is owed downstream
  // unless a reset or flush throws away the buffer and the in-flight word.
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (rst || clr) exq[i].delete();
      else if (rd_en[i]) begin
        if (fq[i].size() > 0) begin
          dout[i] <= fq[i][0];
          exq[i].push_back(fq[i].pop_front());
        end else dout[i] <= 32'hDEAD_BEEF;
      end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    ready[1] = 1'($urandom_range(0, 1));
    hold[1] = ($urandom_range(0, 3) == 0);
    if (fq[1].size() < 4) fq[1].push_back($urandom);
    for (int i = 0; i < 2; i++) empty[i] = (fq[i].size() == 0) || hold[i];
    #1;
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = rd_en[i];
      if (empty[i] || rst || clr) chk("rd_en_gate", rd_en[i], 0);
      chk("buf_cnt_max", cnt[i] <= 2'd2, 1);
      if (stall[i]) begin
        chk("stall_valid", valid[i], 1);
        chk("stall_data", data[i], pd[i]);
        chk("stall_last", last[i], pl[i]);
      end
      if (rst || clr) eb[i] = 0;
      else begin
        chk("last", last[i], valid[i] && (eb[i] == bl[i] - 1));
        if (valid[i] && ready[i]) begin
          chk("data", data[i], exq[i].size() > 0 ? exq[i][0] : 32'hBAD0_BAD0);
          if (exq[i].size() > 0) void'(exq[i].pop_front());
          eb[i] = (eb[i] + 1) % bl[i];
          hs[i]++;
        end
      end
      stall[i] = valid[i] && !ready[i] && !rst && !clr;
      pd[i] = data[i];
      pl[i] = last[i];
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    ready[0] = 1'b0; hold[0] = 1'b0; hold[1] = 1'b0; ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin eb[i] = 0; hs[i] = 0; stall[i] = 1'b0; end
    @(negedge clk);
    repeat (3) cyc();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", valid[i], 0);
      chk("rst_last", last[i], 0);
      chk("rst_data", data[i], 0);
      chk("rst_cnt", cnt[i], 0);
    end
    rst = 1'b0;
    // Streaming with latency and throughput
    for (int v = 0; v < 16; v++) fq[0].push_back(v);
    ready[0] = 1'b1;
    h = hs[0];
    cyc();
    chk("first_rd_en", last_rd[0], 1);
    chk("lat_n1_valid", valid[0], 0);
    cyc();
    chk("lat_n2_valid", valid[0], 1);
    chk("lat_n2_data", data[0], 0);
    repeat (16) cyc();
    chk("stream_throughput", hs[0] - h, 16);
    // Backpressure
    for (int v = 16; v < 48; v++) fq[0].push_back(v);
    h = hs[0];
    repeat (6) cyc();
    ready[0] = 1'b0;
    repeat (5) cyc();
    chk("bp_cnt_sat", cnt[0], 2);
    chk("bp_rd_low", rd_en[0], 0);
    ready[0] = 1'b1;
    repeat (40) cyc();
    chk("bp_all_beats", hs[0] - h, 32);
    chk("bp_owed", exq[0].size(), 0);
    // Underflow: empty flag toggles every cycle
    for (int v = 48; v < 64; v++) fq[0].push_back(v);
    h = hs[0];
    for (int k = 0; k < 50; k++) begin hold[0] = k[0]; cyc(); end
    hold[0] = 1'b0;
    repeat (5) cyc();
    chk("uf_all_beats", hs[0] - h, 16);
    // Flush mid-burst with a read in flight
    for (int v = 64; v < 96; v++) fq[0].push_back(v);
    for (int k = 0; k < 50 && eb[0] != 4; k++) cyc();
    chk("clr_at_beat4", eb[0], 4);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_valid", valid[0], 0);
    chk("clr_cnt", cnt[0], 0);
    chk("clr_last", last[0], 0);
    repeat (40) cyc();
    chk("clr_drained", fq[0].size() + exq[0].size(), 0);
    // Reset with a full buffer
    for (int v = 96; v < 116; v++) fq[0].push_back(v);
    ready[0] = 1'b0;
    for (int k = 0; k < 20 && cnt[0] != 2'd2; k++) cyc();
    chk("pre_rst_cnt", cnt[0], 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", valid[0], 0);
    chk("mid_rst_last", last[0], 0);
    chk("mid_rst_data", data[0], 0);
    chk("mid_rst_cnt", cnt[0], 0);
    pend = fq[0].size();
    h = hs[0];
    ready[0] = 1'b1;
    repeat (40) cyc();
    chk("rst_resume_beats", hs[0] - h, pend);
    // BURST_LEN=1 instance keeps running on random traffic
    for (int k = 0; k < 6000 && hs[1] < 1000; k++) cyc();
    chk("bl1_beats", hs[1] >= 1000, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
